// File: rtl/frv_pipeline_buffer.sv
// Elastic pipeline stage register: a DEPTH-entry circular buffer between two
// pipeline stages, with ready/valid/count driven purely from registered state.
module frv_pipeline_buffer #(
    parameter int RLEN  = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic [RLEN-1:0] i_data,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            flush,
    output logic [RLEN-1:0] o_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [CW-1:0]   o_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high and flush is low; valid never waits on ready.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [RLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;

    assign o_ready = (cnt != CW'(DEPTH));
    assign o_valid = (cnt != '0);
    assign o_count = cnt;
    assign o_data  = o_valid ? mem[rp] : '0;

    assign push = i_valid && o_ready && !flush;
    assign pop  = o_valid && i_ready && !flush;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= next_ptr(wp);
            if (pop)  rp <= next_ptr(rp);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; o_data is masked whenever the buffer is empty.
    always_ff @(posedge g_clk) begin
        if (push) mem[wp] <= i_data;
    end

endmodule

// File: tb/tb_frv_pipeline_buffer.sv
// Bench for frv_pipeline_buffer: a DEPTH=2/RLEN=8 and a DEPTH=3/RLEN=32 instance
// compared every cycle against queue-based reference models.
module tb_frv_pipeline_buffer;

    logic clk;
    logic rst;

    logic        v2, r2, f2, or2, ov2;
    logic [7:0]  d2, od2;
    logic [1:0]  oc2;

    logic        v3, r3, f3, or3, ov3;
    logic [31:0] d3, od3;
    logic [1:0]  oc3;

    int checks;
    int errors;

    logic [7:0]  q2[$];
    logic [31:0] q3[$];
    bit acc2, acc3, pop3;

    frv_pipeline_buffer #(.RLEN(8), .DEPTH(2)) u_d2 (
        .g_clk(clk), .g_reset(rst), .i_data(d2), .i_valid(v2), .o_ready(or2),
        .flush(f2), .o_data(od2), .o_valid(ov2), .i_ready(r2), .o_count(oc2)
    );

    frv_pipeline_buffer #(.RLEN(32), .DEPTH(3)) u_d3 (
        .g_clk(clk), .g_reset(rst), .i_data(d3), .i_valid(v3), .o_ready(or3),
        .flush(f3), .o_data(od3), .o_valid(ov3), .i_ready(r3), .o_count(oc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("d2_valid", 32'(ov2), 32'(q2.size() != 0));
        check("d2_ready", 32'(or2), 32'(q2.size() < 2));
        check("d2_count", 32'(oc2), 32'(q2.size()));
        check("d2_data",  32'(od2), (q2.size() != 0) ? 32'(q2[0]) : 32'h0);
        check("d3_valid", 32'(ov3), 32'(q3.size() != 0));
        check("d3_ready", 32'(or3), 32'(q3.size() < 3));
        check("d3_count", 32'(oc3), 32'(q3.size()));
        check("d3_data",  od3, (q3.size() != 0) ? q3[0] : 32'h0);
    endtask

    // Checks current outputs, advances the models with the driven inputs,
    // then moves to just after the next rising edge.
    task automatic tick();
        bit push, pop;
        check_outputs();
        pop  = (q2.size() > 0) && r2 && !f2;
        push = v2 && (q2.size() < 2) && !f2;
        acc2 = push;
        if (f2) q2.delete();
        else begin
            if (pop)  void'(q2.pop_front());
            if (push) q2.push_back(d2);
        end
        pop  = (q3.size() > 0) && r3 && !f3;
        push = v3 && (q3.size() < 3) && !f3;
        acc3 = push;
        pop3 = pop;
        if (f3) q3.delete();
        else begin
            if (pop)  void'(q3.pop_front());
            if (push) q3.push_back(d3);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_d2_valid", 32'(ov2), 32'h0);
        check("rst_d2_ready", 32'(or2), 32'h1);
        check("rst_d2_count", 32'(oc2), 32'h0);
        check("rst_d2_data",  32'(od2), 32'h0);
        check("rst_d3_valid", 32'(ov3), 32'h0);
        check("rst_d3_ready", 32'(or3), 32'h1);
        check("rst_d3_count", 32'(oc3), 32'h0);
        check("rst_d3_data",  od3, 32'h0);
    endtask

    initial begin
        int idx, recv;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        v2 = 0; r2 = 0; f2 = 0; d2 = '0;
        v3 = 0; r3 = 0; f3 = 0; d3 = '0;

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with two entries held
        v2 = 1; r2 = 0;
        d2 = 8'($urandom); tick();
        d2 = 8'($urandom); tick();
        v2 = 0; tick();
        check("pre_rst_count", 32'(oc2), 32'h2);
        #2 rst = 1'b1;
        #1 check_reset_values();
        q2.delete();
        q3.delete();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        v2 = 1; d2 = 8'hA5; tick();
        v2 = 0;
        check("a5_valid", 32'(ov2), 32'h1);
        check("a5_data", 32'(od2), 32'hA5);
        r2 = 1; tick(); tick();

        // Streaming at one entry per cycle
        r2 = 1;
        for (int i = 1; i <= 6; i++) begin
            v2 = 1; d2 = 8'(i); tick();
            check("stream_ready", 32'(or2), 32'h1);
            check("stream_data", 32'(od2), 32'(i));
        end
        v2 = 0; tick(); tick();

        // Fill then drain with the source holding the rejected entry
        r2 = 0; v2 = 1;
        d2 = 8'h11; tick();
        d2 = 8'h22; tick();
        d2 = 8'h33; tick();
        check("fill_ready", 32'(or2), 32'h0);
        check("fill_count", 32'(oc2), 32'h2);
        r2 = 1;
        for (int i = 0; i < 10 && v2; i++) begin
            tick();
            if (acc2) v2 = 0;
        end
        check("fill_33_accepted", 32'(v2), 32'h0);
        tick(); tick(); tick();

        // Full with a simultaneous pop: no slot opens this cycle
        r2 = 0; v2 = 1;
        d2 = 8'h44; tick();
        d2 = 8'h55; tick();
        d2 = 8'h77; r2 = 1; tick();
        check("full_pop_count", 32'(oc2), 32'h1);
        r2 = 0; tick();
        check("full_next_accept", 32'(oc2), 32'h2);
        v2 = 0; r2 = 1; tick(); tick(); tick();

        // Flush beats a concurrent push and pop
        r2 = 0; v2 = 1;
        d2 = 8'h61; tick();
        d2 = 8'h62; tick();
        d2 = 8'hEE; r2 = 1; f2 = 1; tick();
        f2 = 0; v2 = 0;
        check("flush_count", 32'(oc2), 32'h0);
        check("flush_valid", 32'(ov2), 32'h0);
        check("flush_data", 32'(od2), 32'h0);
        tick(); tick();

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 150; i++) begin
            v2 = 1'($urandom_range(0, 1));
            d2 = 8'($urandom);
            r2 = 1'($urandom_range(0, 1));
            f2 = ($urandom_range(0, 15) == 0);
            tick();
        end
        v2 = 0; f2 = 0; r2 = 1; tick(); tick(); tick();

        // DEPTH=3 wrap-around with stalls on both sides
        idx = 0;
        recv = 0;
        for (int cyc = 0; cyc < 600 && recv < 20; cyc++) begin
            v3 = (idx < 20) && ($urandom_range(0, 3) != 0);
            d3 = 32'hC0DE_0000 + 32'(idx);
            r3 = ($urandom_range(0, 2) != 0);
            tick();
            if (acc3) idx++;
            if (pop3) recv++;
            check("d3_count_le3", 32'(oc3 <= 2'd3), 32'h1);
            check("d3_valid_vs_count", 32'(ov3 == (oc3 != 0)), 32'h1);
        end
        check("d3_received", 32'(recv), 32'd20);
        v3 = 0; r3 = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
